// File: rtl/uidbuf_ic_pkg.sv
// Shared types for the uidbuf read-port round-robin interconnect:
// the FSM state encoding and the grant-index width helper.
package uidbuf_ic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_BUSY = 2'd2,
    ST_GAP  = 2'd3
  } ic_state_e;

  // Width of a channel index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uidbuf_rr_arb.sv
// Round-robin arbiter: picks the first requester after the last granted
// channel (cyclic). Combinational pick plus the last-grant register, which
// only moves when the caller commits a grant (en_i).
module uidbuf_rr_arb
  import uidbuf_ic_pkg::*;
#(
  parameter int CH_NUM = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [CH_NUM-1:0]         req_i,
  input  logic                      en_i,
  output logic [CH_NUM-1:0]         gnt_o,
  output logic [$clog2(CH_NUM)-1:0] gnt_idx_o,
  output logic                      gnt_vld_o
);

  localparam int IDX_W = idx_width(CH_NUM);

  logic [IDX_W-1:0] last_q;

  // Scan from the farthest offset down so the nearest requester after last_q wins.
  always_comb begin
    int cand;
    cand      = 0;
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    for (int off = CH_NUM; off >= 1; off--) begin
      cand = (int'(last_q) + off) % CH_NUM;
      if (req_i[cand]) begin
        gnt_o       = '0;
        gnt_o[cand] = 1'b1;
        gnt_idx_o   = IDX_W'(cand);
        gnt_vld_o   = 1'b1;
      end
    end
  end

  // Remember the committed grant; reset points at the last channel so channel 0 goes first.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= IDX_W'(CH_NUM - 1);
    end else if (en_i && gnt_vld_o) begin
      last_q <= gnt_idx_o;
    end
  end

endmodule

// File: rtl/uidbufr_rr_interconnect.sv
// N-channel FDMA read-port multiplexer with round-robin arbitration.
// One channel owns the FDMA read master per burst; the grant is held until
// the master's busy falls, followed by a one-cycle gap so the client sees
// busy low before the next arbitration.
// Optional watchdog: define FDMA_RD_TIMEOUT_EN to abort a burst stuck in
// REQ/BUSY for TIMEOUT_CYC cycles (rd_timeout pulses for one cycle).
module uidbufr_rr_interconnect
  import uidbuf_ic_pkg::*;
#(
  parameter int CH_NUM         = 4,
  parameter int AXI_DATA_WIDTH = 128,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int SIZE_WIDTH     = 16,
  parameter int TIMEOUT_CYC    = 1024
) (
  input  logic                               ui_clk,
  input  logic                               ui_rstn,
  input  logic [CH_NUM*AXI_ADDR_WIDTH-1:0]   fdma_raddr_ch,
  input  logic [CH_NUM-1:0]                  fdma_rareq_ch,
  input  logic [CH_NUM*SIZE_WIDTH-1:0]       fdma_rsize_ch,
  output logic [CH_NUM-1:0]                  fdma_rbusy_ch,
  output logic [CH_NUM*AXI_DATA_WIDTH-1:0]   fdma_rdata_ch,
  output logic [CH_NUM-1:0]                  fdma_rvalid_ch,
  output logic [AXI_ADDR_WIDTH-1:0]          fdma_raddr,
  output logic                               fdma_rareq,
  output logic [SIZE_WIDTH-1:0]              fdma_rsize,
  input  logic                               fdma_rbusy,
  input  logic [AXI_DATA_WIDTH-1:0]          fdma_rdata,
  input  logic                               fdma_rvalid,
  output logic [$clog2(CH_NUM)-1:0]          grant_id,
  output logic                               rd_timeout
);

  localparam int IDX_W = idx_width(CH_NUM);

  ic_state_e                         state_q;
  logic [IDX_W-1:0]                  grant_id_q;
  logic [CH_NUM-1:0]                 grant_oh_q;
  logic [AXI_ADDR_WIDTH-1:0]         raddr_q;
  logic [SIZE_WIDTH-1:0]             rsize_q;
  logic                              rareq_q;
  logic                              rbusy_d1_q;
  logic [CH_NUM-1:0]                 rbusy_ch_q;
  logic [CH_NUM-1:0]                 rvalid_ch_q;
  logic [CH_NUM*AXI_DATA_WIDTH-1:0]  rdata_ch_q;

  logic [CH_NUM-1:0]                 arb_gnt;
  logic [IDX_W-1:0]                  arb_idx;
  logic                              arb_vld;
  logic                              arb_en;

  assign arb_en = (state_q == ST_IDLE);

  uidbuf_rr_arb #(
    .CH_NUM (CH_NUM)
  ) u_arb (
    .clk_i     (ui_clk),
    .rst_ni    (ui_rstn),
    .req_i     (fdma_rareq_ch),
    .en_i      (arb_en),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx),
    .gnt_vld_o (arb_vld)
  );

`ifdef FDMA_RD_TIMEOUT_EN
  logic [15:0] to_cnt_q;
  logic        to_hit;
  logic        rd_timeout_q;

  // Watchdog fires on the TIMEOUT_CYC-th cycle spent in REQ or BUSY.
  assign to_hit = ((state_q == ST_REQ) || (state_q == ST_BUSY)) &&
                  (to_cnt_q == 16'(TIMEOUT_CYC - 1));
  assign rd_timeout = rd_timeout_q;
`else
  assign rd_timeout = 1'b0;
`endif

  // Burst-ownership FSM: arbitrate, issue the request, track busy, then gap.
  always_ff @(posedge ui_clk or negedge ui_rstn) begin
    if (!ui_rstn) begin
      state_q    <= ST_IDLE;
      grant_id_q <= '0;
      grant_oh_q <= '0;
      raddr_q    <= '0;
      rsize_q    <= '0;
      rareq_q    <= 1'b0;
      rbusy_d1_q <= 1'b0;
`ifdef FDMA_RD_TIMEOUT_EN
      to_cnt_q     <= '0;
      rd_timeout_q <= 1'b0;
`endif
    end else begin
      rbusy_d1_q <= fdma_rbusy;
`ifdef FDMA_RD_TIMEOUT_EN
      rd_timeout_q <= 1'b0;
      to_cnt_q     <= to_cnt_q + 16'd1;
`endif
      case (state_q)
        ST_IDLE: begin
          if (arb_vld) begin
            grant_id_q <= arb_idx;
            grant_oh_q <= arb_gnt;
            state_q    <= ST_REQ;
`ifdef FDMA_RD_TIMEOUT_EN
            to_cnt_q   <= '0;
`endif
          end
        end
        ST_REQ: begin
          raddr_q <= fdma_raddr_ch[int'(grant_id_q)*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
          rsize_q <= fdma_rsize_ch[int'(grant_id_q)*SIZE_WIDTH +: SIZE_WIDTH];
          if (fdma_rbusy) begin
            rareq_q <= 1'b0;
            state_q <= ST_BUSY;
`ifdef FDMA_RD_TIMEOUT_EN
            to_cnt_q <= '0;
`endif
          end else begin
            rareq_q <= 1'b1;
          end
        end
        ST_BUSY: begin
          // Falling edge of the master's busy ends the burst.
          if (rbusy_d1_q && !fdma_rbusy) begin
            state_q <= ST_GAP;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
`ifdef FDMA_RD_TIMEOUT_EN
      // last_grant already points at the stalled channel, so the next
      // arbitration starts after it.
      if (to_hit) begin
        rareq_q      <= 1'b0;
        rd_timeout_q <= 1'b1;
        to_cnt_q     <= '0;
        state_q      <= ST_GAP;
      end
`endif
    end
  end

  // Forward master busy/valid/data to the owning channel only while in BUSY.
  always_ff @(posedge ui_clk or negedge ui_rstn) begin
    if (!ui_rstn) begin
      rbusy_ch_q  <= '0;
      rvalid_ch_q <= '0;
      rdata_ch_q  <= '0;
    end else begin
      for (int k = 0; k < CH_NUM; k++) begin
        if ((state_q == ST_BUSY) && grant_oh_q[k]) begin
          rbusy_ch_q[k]                                  <= fdma_rbusy;
          rvalid_ch_q[k]                                 <= fdma_rvalid;
          rdata_ch_q[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= fdma_rdata;
        end else begin
          rbusy_ch_q[k]                                  <= 1'b0;
          rvalid_ch_q[k]                                 <= 1'b0;
          rdata_ch_q[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= '0;
        end
      end
    end
  end

  assign fdma_raddr     = raddr_q;
  assign fdma_rsize     = rsize_q;
  assign fdma_rareq     = rareq_q;
  assign grant_id       = grant_id_q;
  assign fdma_rbusy_ch  = rbusy_ch_q;
  assign fdma_rvalid_ch = rvalid_ch_q;
  assign fdma_rdata_ch  = rdata_ch_q;

endmodule

// File: doc/uidbufr_rr_interconnect.md
Name: uidbufr_rr_interconnect

Overview:
- Parametrised N-channel FDMA read-port multiplexer. It sits between CH_NUM uidbuf read-side clients and the single FDMA read master in the DDR read path.
- Replaces fixed-priority 4-channel arbitration with round-robin arbitration, so no channel is starved.
- Adds an explicit request/busy handshake state machine and a configurable channel count.
- Exactly one burst is owned by one channel at a time. The grant is held until the FDMA read burst completes.

Parameters:
- CH_NUM, 4, number of client channels (2..8).
- AXI_DATA_WIDTH, 128, FDMA read data width.
- AXI_ADDR_WIDTH, 32, FDMA address width.
- SIZE_WIDTH, 16, burst-size field width.
- TIMEOUT_CYC, 1024, watchdog limit in cycles (used only with the optional feature).

Ports:
- ui_clk  in  1  single clock.
- ui_rstn  in  1  asynchronous active-low reset.
- fdma_raddr_ch  in  CH_NUM*AXI_ADDR_WIDTH  per-channel read address, channel k at slice k.
- fdma_rareq_ch  in  CH_NUM  per-channel request, level, held until that channel's busy rises.
- fdma_rsize_ch  in  CH_NUM*SIZE_WIDTH  per-channel burst length in beats.
- fdma_rbusy_ch  out  CH_NUM  per-channel busy.
- fdma_rdata_ch  out  CH_NUM*AXI_DATA_WIDTH  per-channel read data.
- fdma_rvalid_ch  out  CH_NUM  per-channel data valid.
- fdma_raddr  out  AXI_ADDR_WIDTH  to FDMA master.
- fdma_rareq  out  1  to FDMA master.
- fdma_rsize  out  SIZE_WIDTH  to FDMA master.
- fdma_rbusy  in  1  from FDMA master.
- fdma_rdata  in  AXI_DATA_WIDTH  from FDMA master.
- fdma_rvalid  in  1  from FDMA master.
- grant_id  out  $clog2(CH_NUM)  currently owned channel, debug.
- rd_timeout  out  1  one-cycle timeout pulse; tied 0 when the optional feature is compiled out.

Behaviour:
- Reset: every output is 0, state is IDLE, and last_grant is CH_NUM-1, so channel 0 has highest priority first.
- IDLE:
  - When any fdma_rareq_ch bit is set, select the first requesting channel after last_grant (cyclic).
  - Latch its index into grant_id and last_grant, then go to REQ.
  - With no requests, remain in IDLE.
- REQ:
  - Drive fdma_rareq=1 with fdma_raddr/fdma_rsize taken from the granted slice, registered.
  - On fdma_rbusy=1, drop fdma_rareq and go to BUSY.
- BUSY:
  - fdma_rbusy, fdma_rvalid and fdma_rdata are forwarded to the granted channel's outputs through one register stage (latency 1 cycle).
  - Non-granted channel outputs are forced to 0.
  - On the fdma_rbusy falling edge (registered delay compare), go to GAP.
- GAP:
  - Lasts one cycle. All channel outputs are 0, then go to IDLE.
  - This guarantees the client sees busy low before any re-arbitration.
- Latency:
  - Request to fdma_rareq is 2 cycles (IDLE decision, REQ register).
  - Back-to-back bursts are separated by at least 2 idle cycles (GAP, IDLE).
- Simultaneous requests are served strictly in round-robin order. A channel that re-requests immediately waits behind all other pending channels.
- A requester dropping fdma_rareq_ch while in REQ does not cancel the grant; the burst completes as issued.
- fdma_rvalid outside BUSY is ignored and never forwarded.
- fdma_rsize=0 is passed through unchanged; no width conversion or checking is done.
- Reset asserted mid-burst returns to IDLE immediately. Data in flight is dropped and last_grant is reinitialised.
- State encoding: IDLE=0, REQ=1, BUSY=2, GAP=3.

Optional Feature:
- FDMA_RD_TIMEOUT_EN defined:
  - A 16-bit counter runs in REQ and BUSY and clears on each state entry.
  - If it reaches TIMEOUT_CYC, force fdma_rareq=0, pulse rd_timeout for 1 cycle, go to GAP, and advance last_grant.
- Undefined: no counter, rd_timeout is constant 0, and the FSM can wait indefinitely.

Decomposition:
- Package uidbuf_ic_pkg holds the state enum (IDLE/REQ/BUSY/GAP) and a grant index width function.
- Natural sub-module: uidbuf_rr_arb. It is combinational plus last_grant register; inputs are the request vector and enable, outputs are a one-hot grant and index.

Test Plan:
- Single channel 2, addr 0x0010_0000, size 240: fdma_rareq high 2 cycles after request, then 240 rvalid beats appear on channel 2 only, delayed 1 cycle; other channels stay 0.
- All 4 channels requesting continuously after reset: grant order 0,1,2,3,0,1; each grant is separated by a busy fall plus 2 cycles.
- Channel 1 re-requests during its own burst while channel 3 waits: next grant is 3, then 1.
- ui_rstn pulsed low mid-BUSY (beat 50 of 240): all outputs 0 asynchronously; after release, channel 0 is the first grant.
- Stray fdma_rvalid in IDLE: no channel rvalid asserted.
- With FDMA_RD_TIMEOUT_EN and TIMEOUT_CYC=64, fdma_rbusy never rising: rd_timeout pulses at cycle 64 of REQ, and the next requesting channel is granted.
